// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I load/store encodings and MEM-stage state type
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed byte/halfword of a load word
module load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (addr_lo)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        // Unused encodings fall through to a full-word load.
        case (funct3)
            F3_B:    result = {{24{byte_v[7]}}, byte_v};
            F3_BU:   result = {24'd0, byte_v};
            F3_H:    result = {{16{half_v[15]}}, half_v};
            F3_HU:   result = {16'd0, half_v};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - RV32I MEM stage with variable-latency data-memory handshake
module memory_access
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_MEM_ALU_OUT,
    input  logic [31:0] EX_MEM_writedata,
    input  logic [4:0]  EX_MEM_RD,
    input  logic [2:0]  EX_MEM_funct3,
    input  logic        EX_MEM_memwrite_en,
    input  logic        EX_MEM_regwrite_en,
    input  logic        EX_MEM_wb_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic [31:0] MEM_WB_RESULT,
    output logic [4:0]  MEM_WB_RD,
    output logic        MEM_WB_regwrite_en,
    output logic        misaligned_err,
    output logic        bus_err
);

    mem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_lat_q, rd_lat_d;
    logic        rw_lat_q, rw_lat_d;
    logic        load_q, load_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d;
    logic        mis_q, mis_d;
    logic        bus_q, bus_d;

    logic        access;
    logic        misaligned;
    logic        timeout_hit;
    logic        stall_c;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] load_result;

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (alu_q[1:0]),
        .funct3  (f3_q),
        .result  (load_result)
    );

    always_comb begin
        access     = EX_MEM_wb_sel | EX_MEM_memwrite_en;
        misaligned = access &&
                     (((EX_MEM_funct3[1:0] == 2'b01) && EX_MEM_ALU_OUT[0]) ||
                      ((EX_MEM_funct3[1:0] == 2'b10) && (EX_MEM_ALU_OUT[1:0] != 2'b00)));
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        // Store lanes; loads read the whole word and extract afterwards.
        st_be    = 4'b1111;
        st_wdata = 32'd0;
        if (EX_MEM_memwrite_en) begin
            case (EX_MEM_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << EX_MEM_ALU_OUT[1:0];
                    st_wdata = {4{EX_MEM_writedata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << {EX_MEM_ALU_OUT[1], 1'b0};
                    st_wdata = {2{EX_MEM_writedata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = EX_MEM_writedata;
                end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        alu_d    = alu_q;
        rd_lat_d = rd_lat_q;
        rw_lat_d = rw_lat_q;
        load_d   = load_q;
        f3_d     = f3_q;
        result_d = result_q;
        wb_rd_d  = wb_rd_q;
        wb_rw_d  = wb_rw_q;
        mis_d    = 1'b0;
        bus_d    = 1'b0;
        stall_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!access) begin
                    result_d = EX_MEM_ALU_OUT;
                    wb_rd_d  = EX_MEM_RD;
                    wb_rw_d  = EX_MEM_regwrite_en;
                end else if (misaligned) begin
                    mis_d   = 1'b1;
                    wb_rw_d = 1'b0;
                end else begin
                    req_d    = 1'b1;
                    we_d     = EX_MEM_memwrite_en;
                    be_d     = st_be;
                    wdata_d  = st_wdata;
                    alu_d    = EX_MEM_ALU_OUT;
                    rd_lat_d = EX_MEM_RD;
                    rw_lat_d = EX_MEM_regwrite_en;
                    load_d   = ~EX_MEM_memwrite_en;
                    f3_d     = EX_MEM_funct3;
                    cnt_d    = '0;
                    state_d  = S_REQ;
                    stall_c  = 1'b1;
                    wb_rw_d  = 1'b0;
                end
            end
            S_REQ: begin
                // Completion takes priority over an expiring timeout.
                if (dmem_ready) begin
                    result_d = load_q ? load_result : alu_q;
                    wb_rd_d  = rd_lat_q;
                    wb_rw_d  = rw_lat_q;
                    req_d    = 1'b0;
                    state_d  = S_IDLE;
                end else if (timeout_hit) begin
                    wb_rw_d = 1'b0;
                    req_d   = 1'b0;
                    bus_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wb_rw_d = 1'b0;
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            alu_q    <= 32'd0;
            rd_lat_q <= 5'd0;
            rw_lat_q <= 1'b0;
            load_q   <= 1'b0;
            f3_q     <= 3'd0;
            result_q <= 32'd0;
            wb_rd_q  <= 5'd0;
            wb_rw_q  <= 1'b0;
            mis_q    <= 1'b0;
            bus_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            alu_q    <= alu_d;
            rd_lat_q <= rd_lat_d;
            rw_lat_q <= rw_lat_d;
            load_q   <= load_d;
            f3_q     <= f3_d;
            result_q <= result_d;
            wb_rd_q  <= wb_rd_d;
            wb_rw_q  <= wb_rw_d;
            mis_q    <= mis_d;
            bus_q    <= bus_d;
        end
    end

    assign dmem_req           = req_q;
    assign dmem_we            = we_q;
    assign dmem_addr          = {alu_q[31:2], 2'b00};
    assign dmem_wdata         = wdata_q;
    assign dmem_be            = be_q;
    assign mem_stall          = stall_c & ~rst;
    assign MEM_WB_RESULT      = result_q;
    assign MEM_WB_RD          = wb_rd_q;
    assign MEM_WB_regwrite_en = wb_rw_q;
    assign misaligned_err     = mis_q;
    assign bus_err            = bus_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - directed vector bench for the MEM stage
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_out = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        memwrite_en = 1'b0;
    logic        regwrite_en = 1'b0;
    logic        wb_sel = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ready = 1'b0;
    logic        mem_stall;
    logic [31:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_rw;
    logic        misaligned_err, bus_err;

    int checks = 0;
    int errors = 0;

    memory_access #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
        .clk                (clk),
        .rst                (rst),
        .EX_MEM_ALU_OUT     (alu_out),
        .EX_MEM_writedata   (writedata),
        .EX_MEM_RD          (rd),
        .EX_MEM_funct3      (funct3),
        .EX_MEM_memwrite_en (memwrite_en),
        .EX_MEM_regwrite_en (regwrite_en),
        .EX_MEM_wb_sel      (wb_sel),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_rdata         (dmem_rdata),
        .dmem_ready         (dmem_ready),
        .mem_stall          (mem_stall),
        .MEM_WB_RESULT      (wb_result),
        .MEM_WB_RD          (wb_rd),
        .MEM_WB_regwrite_en (wb_rw),
        .misaligned_err     (misaligned_err),
        .bus_err            (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        wb_sel;
        logic        mw;
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        int          waits;
        logic [31:0] rdata;
        logic        e_acc;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
        logic        e_rw;
        logic        e_mis;
        logic        chk_res;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ws, input logic mw, input logic rw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
        wb_sel      = ws;
        memwrite_en = mw;
        regwrite_en = rw;
        funct3      = f3;
        alu_out     = a;
        writedata   = wd;
        rd          = r;
    endtask

    task automatic apply(input int idx, input vec_t v);
        int stall_cnt;
        stall_cnt = 0;
        @(negedge clk);
        drive(v.wb_sel, v.mw, v.rw, v.f3, v.alu, v.wd, v.rd);
        dmem_ready = 1'b0;
        #1;
        if (mem_stall) stall_cnt++;
        chk($sformatf("v%0d stall_issue", idx), {31'd0, mem_stall}, {31'd0, v.e_acc});
        @(posedge clk);
        #1;
        if (v.e_acc) begin
            chk($sformatf("v%0d req", idx), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("v%0d we", idx), {31'd0, dmem_we}, {31'd0, v.e_we});
            chk($sformatf("v%0d addr", idx), dmem_addr, v.e_addr);
            chk($sformatf("v%0d be", idx), {28'd0, dmem_be}, {28'd0, v.e_be});
            if (v.e_we) chk($sformatf("v%0d wdata", idx), dmem_wdata, v.e_wdata);
            chk($sformatf("v%0d rw_bubble", idx), {31'd0, wb_rw}, 32'd0);
            chk($sformatf("v%0d mis_idle", idx), {31'd0, misaligned_err}, 32'd0);
            // Upstream noise while outstanding must be ignored.
            drive(1'b1, 1'b1, ~v.rw, 3'b010, ~v.alu & 32'hFFFF_FFFC, ~v.wd, ~v.rd);
            for (int i = 0; i < v.waits; i++) begin
                @(negedge clk);
                #1;
                if (mem_stall) stall_cnt++;
                @(posedge clk);
                #1;
                chk($sformatf("v%0d req_hold", idx), {31'd0, dmem_req}, 32'd1);
                chk($sformatf("v%0d addr_hold", idx), dmem_addr, v.e_addr);
            end
            @(negedge clk);
            dmem_ready = 1'b1;
            dmem_rdata = v.rdata;
            #1;
            if (mem_stall) stall_cnt++;
            @(posedge clk);
            #1;
            dmem_ready = 1'b0;
            chk($sformatf("v%0d req_done", idx), {31'd0, dmem_req}, 32'd0);
            chk($sformatf("v%0d stall_cycles", idx), stall_cnt, v.waits + 1);
            chk($sformatf("v%0d bus_err", idx), {31'd0, bus_err}, 32'd0);
        end else begin
            chk($sformatf("v%0d no_req", idx), {31'd0, dmem_req}, 32'd0);
            chk($sformatf("v%0d mis", idx), {31'd0, misaligned_err}, {31'd0, v.e_mis});
        end
        if (v.chk_res) begin
            chk($sformatf("v%0d result", idx), wb_result, v.e_res);
            chk($sformatf("v%0d rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
        end
        chk($sformatf("v%0d regwrite", idx), {31'd0, wb_rw}, {31'd0, v.e_rw});
    endtask

    initial begin
        int  n;
        logic seen;
        logic st;

        //          ws mw rw f3      alu           wd            rd  w  rdata          acc we be       addr         wdata          res           erw mis chk
        vecs[0]  = '{0, 0, 1, 3'b000, 32'h0000_1234, 32'h0,        5,  0, 32'h0,         0, 0, 4'h0,    32'h0,       32'h0,         32'h0000_1234, 1, 0, 1};
        vecs[1]  = '{0, 0, 0, 3'b000, 32'hCAFE_BABE, 32'h1111,     7,  0, 32'h0,         0, 0, 4'h0,    32'h0,       32'h0,         32'hCAFE_BABE, 0, 0, 1};
        vecs[2]  = '{0, 1, 0, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0,         1, 1, 4'b1111, 32'h104,     32'hDEAD_BEEF, 32'h0000_0104, 0, 0, 1};
        vecs[3]  = '{1, 0, 1, 3'b000, 32'h0000_0203, 32'h0,        10, 3, 32'h80FF_0011, 1, 0, 4'b1111, 32'h200,     32'h0,         32'hFFFF_FF80, 1, 0, 1};
        vecs[4]  = '{1, 0, 1, 3'b101, 32'h0000_0202, 32'h0,        11, 1, 32'h8001_7F00, 1, 0, 4'b1111, 32'h200,     32'h0,         32'h0000_8001, 1, 0, 1};
        vecs[5]  = '{0, 1, 0, 3'b000, 32'h0000_0001, 32'h1234_56AB, 0, 2, 32'h0,         1, 1, 4'b0010, 32'h0,       32'hABAB_ABAB, 32'h0000_0001, 0, 0, 1};
        vecs[6]  = '{0, 1, 0, 3'b001, 32'h0000_0006, 32'h0000_BEEF, 2, 0, 32'h0,         1, 1, 4'b1100, 32'h4,       32'hBEEF_BEEF, 32'h0000_0006, 0, 0, 1};
        vecs[7]  = '{1, 0, 1, 3'b001, 32'h0000_0000, 32'h0,        12, 1, 32'h1234_8765, 1, 0, 4'b1111, 32'h0,       32'h0,         32'hFFFF_8765, 1, 0, 1};
        vecs[8]  = '{1, 0, 1, 3'b010, 32'h0000_0100, 32'h0,        13, 0, 32'h89AB_CDEF, 1, 0, 4'b1111, 32'h100,     32'h0,         32'h89AB_CDEF, 1, 0, 1};
        vecs[9]  = '{1, 0, 1, 3'b100, 32'h0000_0002, 32'h0,        14, 2, 32'h00C3_0000, 1, 0, 4'b1111, 32'h0,       32'h0,         32'h0000_00C3, 1, 0, 1};
        vecs[10] = '{1, 0, 1, 3'b011, 32'h0000_0008, 32'h0,        15, 0, 32'h55AA_55AA, 1, 0, 4'b1111, 32'h8,       32'h0,         32'h55AA_55AA, 1, 0, 1};
        vecs[11] = '{1, 0, 1, 3'b010, 32'h0000_0102, 32'h0,        16, 0, 32'h0,         0, 0, 4'h0,    32'h0,       32'h0,         32'h0,         0, 1, 0};
        vecs[12] = '{1, 0, 1, 3'b001, 32'h0000_0101, 32'h0,        17, 0, 32'h0,         0, 0, 4'h0,    32'h0,       32'h0,         32'h0,         0, 1, 0};
        vecs[13] = '{1, 1, 1, 3'b010, 32'h0000_0010, 32'h0BAD_F00D, 3, 1, 32'hFFFF_FFFF, 1, 1, 4'b1111, 32'h10,      32'h0BAD_F00D, 32'h0000_0010, 1, 0, 1};
        vecs[14] = '{0, 1, 0, 3'b001, 32'h0000_0003, 32'h0000_1234, 0, 0, 32'h0,         0, 0, 4'h0,    32'h0,       32'h0,         32'h0,         0, 1, 0};
        vecs[15] = '{0, 0, 1, 3'b000, 32'hA5A5_0001, 32'h0,        19, 0, 32'h0,         0, 0, 4'h0,    32'h0,       32'h0,         32'hA5A5_0001, 1, 0, 1};
        vecs[16] = '{1, 0, 1, 3'b000, 32'h0000_0001, 32'h0,        18, 0, 32'h0000_7F00, 1, 0, 4'b1111, 32'h0,       32'h0,         32'h0000_007F, 1, 0, 1};

        #12;
        chk("reset req", {31'd0, dmem_req}, 32'd0);
        chk("reset stall", {31'd0, mem_stall}, 32'd0);
        chk("reset be", {28'd0, dmem_be}, 32'd0);
        chk("reset addr", dmem_addr, 32'd0);
        chk("reset result", wb_result, 32'd0);
        chk("reset regwrite", {31'd0, wb_rw}, 32'd0);
        chk("reset errs", {30'd0, misaligned_err, bus_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) apply(i, vecs[i]);

        // Timeout: ready never arrives.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd9);
        dmem_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("to req", {31'd0, dmem_req}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0077, 32'h0, 5'd12);
        n = 0;
        seen = 1'b0;
        st = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            #1;
            st = mem_stall;
            @(posedge clk);
            #1;
            n++;
            if (bus_err) seen = 1'b1;
        end
        chk("to seen", {31'd0, seen}, 32'd1);
        chk("to req_cycles", n, 32'd4);
        chk("to stall_last", {31'd0, st}, 32'd0);
        chk("to req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to regwrite", {31'd0, wb_rw}, 32'd0);
        chk("to stall_idle", {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("to bus_pulse", {31'd0, bus_err}, 32'd0);
        chk("to next_result", wb_result, 32'h0000_0077);
        chk("to next_rd", {27'd0, wb_rd}, 32'd12);
        chk("to next_rw", {31'd0, wb_rw}, 32'd1);

        // Reset while a store is outstanding.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h1357_9BDF, 5'd0);
        @(posedge clk);
        #1;
        chk("rst req_before", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst req", {31'd0, dmem_req}, 32'd0);
        chk("rst stall", {31'd0, mem_stall}, 32'd0);
        chk("rst be", {28'd0, dmem_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_5555, 32'h0, 5'd4);
        #1;
        chk("rst post_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst post_result", wb_result, 32'h0000_5555);
        chk("rst post_rd", {27'd0, wb_rd}, 32'd4);
        chk("rst post_rw", {31'd0, wb_rw}, 32'd1);
        chk("rst post_req", {31'd0, dmem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the RV32I core. Sits directly downstream of the execute stage.
- Consumes the EX/MEM register outputs: ALU result, store data, rd, and the memwrite, regwrite and wb_sel controls.
- Performs loads and stores over a variable-latency data-memory handshake, stalling upstream while an access is outstanding.
- Produces the MEM/WB pipeline register: result, rd and regwrite_en. Also flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: cycles in REQ without dmem_ready before the access is aborted. 0 disables the timeout.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- EX_MEM_ALU_OUT  in  32  effective address, or non-memory result
- EX_MEM_writedata  in  32  store data (rs2)
- EX_MEM_RD  in  5  destination register
- EX_MEM_funct3  in  3  access size and sign
- EX_MEM_memwrite_en  in  1  store
- EX_MEM_regwrite_en  in  1  writes rd
- EX_MEM_wb_sel  in  1  1 = load (result comes from memory)
- dmem_req  out  1  request valid, registered
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read data, valid when dmem_ready=1
- dmem_ready  in  1  access completes this cycle
- mem_stall  out  1  upstream must hold EX/MEM contents
- MEM_WB_RESULT  out  32  writeback value
- MEM_WB_RD  out  5  writeback rd
- MEM_WB_regwrite_en  out  1  writeback enable
- misaligned_err  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, any state): state=IDLE; all registered outputs 0, including dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, MEM_WB_*, misaligned_err, bus_err and the counter.
  - An in-flight request is dropped with no completion.
  - mem_stall is 0 in reset.
- access = EX_MEM_wb_sel | EX_MEM_memwrite_en.
- Misalignment rule:
  - Halfword (funct3[1:0]=01) with addr[0]=1 is misaligned.
  - Word (funct3[1:0]=10) with addr[1:0]!=0 is misaligned.
- FSM states: IDLE, REQ.
- IDLE, no access: MEM_WB_RESULT<=ALU_OUT, MEM_WB_RD<=RD, MEM_WB_regwrite_en<=regwrite_en. mem_stall=0. Throughput 1 per cycle.
- IDLE, access misaligned:
  - No request is issued.
  - misaligned_err<=1 for one cycle.
  - MEM_WB_regwrite_en<=0 (bubble).
  - mem_stall=0.
- IDLE, access aligned:
  - Register dmem_req=1, dmem_we, dmem_addr, dmem_be and dmem_wdata.
  - Move to REQ with the counter cleared.
  - mem_stall=1; MEM_WB_regwrite_en<=0.
- REQ: request outputs are held stable. mem_stall = ~dmem_ready.
  - On dmem_ready=1:
    - Load: MEM_WB_RESULT<=extracted load data.
    - Store: MEM_WB_RESULT<=ALU_OUT.
    - MEM_WB_RD<=RD; MEM_WB_regwrite_en<=regwrite_en.
    - dmem_req<=0; move to IDLE.
  - Otherwise: MEM_WB_regwrite_en<=0 and the counter increments.
  - Timeout: if the counter reaches TIMEOUT_CYCLES-1 with no dmem_ready:
    - dmem_req<=0; bus_err pulses.
    - MEM_WB_regwrite_en<=0; mem_stall=0.
    - Move to IDLE.
  - When dmem_ready and the timeout coincide, ready wins.
- Minimum access latency: 2 cycles (IDLE issue, REQ with ready). Each extra wait cycle adds 1.
- Store lane mapping:
  - SB (000): be=4'b0001<<addr[1:0]; wdata={4{wd[7:0]}}.
  - SH (001): be=4'b0011<<{addr[1],1'b0}; wdata={2{wd[15:0]}}.
  - SW (010): be=4'b1111; wdata=wd.
- Loads always drive be=4'b1111 and we=0.
- Load extraction uses the latched addr[1:0]:
  - LB (000): selected byte, sign-extended.
  - LBU (100): selected byte, zero-extended.
  - LH (001): selected halfword, sign-extended.
  - LHU (101): selected halfword, zero-extended.
  - LW (010): full word.
  - Encodings 011, 110, 111 are treated as LW.
- Simultaneous memwrite_en=1 and wb_sel=1: the access is treated as a store.
- Inputs are sampled only in IDLE. Upstream changes while in REQ are ignored.

Decomposition:
- Shared package rv32i_pkg:
  - funct3 load/store localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State encodings: S_IDLE, S_REQ.
- Sub-module load_align: combinational rdata/addr[1:0]/funct3 → 32-bit extended result.
- Store lane logic stays inline.

Test Plan:
- ALU op, regwrite=1, RD=5, ALU_OUT=0x1234 → next edge MEM_WB_RESULT=0x1234, RD=5, regwrite_en=1, stall=0, no dmem_req.
- SW addr=0x104, data=0xDEADBEEF, ready after 0 waits → dmem_req 1 cycle, be=1111, addr=0x104; stall high exactly 1 cycle; MEM_WB_regwrite_en=0.
- LB addr=0x203, rdata=0x80FF_0011, ready after 3 waits → MEM_WB_RESULT=0xFFFF_FF80; stall high 4 cycles.
- LHU addr=0x202, rdata=0x8001_7F00 → 0x0000_8001. SB addr=0x01, data=0xAB → be=0010, wdata=0xABABABAB.
- LW addr=0x102 → misaligned_err pulses 1 cycle; no dmem_req; MEM_WB_regwrite_en=0. TIMEOUT_CYCLES=4 with ready held low → bus_err after 4 REQ cycles, state IDLE.
- rst asserted mid-REQ → dmem_req=0 and stall=0 immediately without a clock; after release, a following ALU op passes normally.
